leak_recover: RTL and testbench

LEAK_RECOVER -- requirements
Module: leak_recover

---
 rtl/leak_pkg.sv | 21 ++
 rtl/leak_recover_lfsr64.sv | 22 ++
 rtl/leak_recover.sv | 120 ++++++++++++
 tb/tb_leak_recover.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/leak_pkg.sv
// Shared types and constants for the leakage-channel key recovery receiver.
package leak_pkg;

    localparam int WORD_W = 64;

    // Fibonacci taps 64,63,61,60 expressed as state bits 63,62,60,59
    localparam logic [WORD_W-1:0] LFSR_TAPS    = 64'hD800_0000_0000_0000;
    localparam logic [WORD_W-1:0] DEFAULT_SEED = 64'hA5A5_0F0F_3C3C_9669;

    typedef enum logic [1:0] {
        IDLE,
        CAP_LO,
        CAP_HI,
        VOTE
    } state_t;

    function automatic logic [WORD_W-1:0] lfsr_next(input logic [WORD_W-1:0] s);
        return {s[WORD_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/leak_recover_lfsr64.sv
// 64-bit Fibonacci LFSR mirroring the transmitter's whitening sequence.
module lfsr64
    import leak_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              enable,
    input  logic [WORD_W-1:0] seed,
    output logic [WORD_W-1:0] state
);

    // Reset and load both return to the seed; load wins over stepping
    always_ff @(posedge clk) begin
        if (rst || load) begin
            state <= seed;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/leak_recover.sv
// Recovers a 128-bit key from LFSR-whitened leakage words by majority vote
// over NUM_FRAMES repeated transmissions.
module leak_recover
    import leak_pkg::*;
#(
    parameter int                NUM_FRAMES = 3,
    parameter logic [WORD_W-1:0] LFSR_SEED  = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] Capacitance,
    output logic [127:0]      key_out,
    output logic              key_valid,
    output logic              busy,
    output logic              disagree
);

    localparam int CNT_W = $clog2(NUM_FRAMES + 1);
    localparam int FRM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [CNT_W-1:0] HALF       = CNT_W'(NUM_FRAMES / 2);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(NUM_FRAMES);
    localparam logic [FRM_W-1:0] LAST_FRAME = FRM_W'(NUM_FRAMES - 1);

    state_t              state, state_nx;
    logic [FRM_W-1:0]    frame;
    logic [CNT_W-1:0]    ones [128];
    logic [127:0]        key_reg;
    logic [127:0]        vote_key;
    logic                vote_mixed;
    logic [WORD_W-1:0]   lfsr_state;
    logic [WORD_W-1:0]   decoded;
    logic                capturing;

    assign capturing = (state == CAP_LO) || (state == CAP_HI);
    assign decoded   = Capacitance ^ lfsr_state;

    lfsr64 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .enable (capturing),
        .seed   (LFSR_SEED),
        .state  (lfsr_state)
    );

    always_comb begin
        vote_key   = '0;
        vote_mixed = 1'b0;
        for (int i = 0; i < 128; i++) begin
            vote_key[i] = (ones[i] > HALF);
            if ((ones[i] != '0) && (ones[i] != FULL)) begin
                vote_mixed = 1'b1;
            end
        end
    end

    // key_out shows the fresh vote during VOTE and the held copy otherwise
    always_comb begin
        state_nx  = state;
        busy      = capturing;
        key_valid = 1'b0;
        disagree  = 1'b0;
        key_out   = key_reg;
        case (state)
            IDLE:   if (start) state_nx = CAP_LO;
            CAP_LO: state_nx = start ? CAP_LO : CAP_HI;
            CAP_HI: begin
                if (start || (frame < LAST_FRAME)) begin
                    state_nx = CAP_LO;
                end else begin
                    state_nx = VOTE;
                end
            end
            VOTE: begin
                state_nx  = start ? CAP_LO : IDLE;
                key_valid = 1'b1;
                disagree  = vote_mixed;
                key_out   = vote_key;
            end
            default: state_nx = IDLE;
        endcase
    end

    // A start anywhere discards partial counts; the VOTE result is latched regardless
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            frame   <= '0;
            key_reg <= '0;
            for (int i = 0; i < 128; i++) begin
                ones[i] <= '0;
            end
        end else begin
            state <= state_nx;
            if (state == VOTE) begin
                key_reg <= vote_key;
            end
            if (start) begin
                frame <= '0;
                for (int i = 0; i < 128; i++) begin
                    ones[i] <= '0;
                end
            end else begin
                if ((state == CAP_HI) && (frame < LAST_FRAME)) begin
                    frame <= frame + 1'b1;
                end
                for (int i = 0; i < WORD_W; i++) begin
                    if ((state == CAP_LO) && decoded[i]) begin
                        ones[i] <= ones[i] + 1'b1;
                    end
                    if ((state == CAP_HI) && decoded[i]) begin
                        ones[i + WORD_W] <= ones[i + WORD_W] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_leak_recover.sv
// Scoreboard bench for leak_recover: a transmitter model whitens keys, a
// monitor compares every key_valid against the queued majority-vote result.
module tb_leak_recover;
    import leak_pkg::*;

    localparam int          N    = 3;
    localparam logic [63:0] SEED = 64'hA5A5_0F0F_3C3C_9669;

    typedef struct {
        logic [127:0] key;
        logic         dis;
        int           at;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  Capacitance;
    logic [127:0] key_out;
    logic         key_valid;
    logic         busy;
    logic         disagree;
    logic         tx_load;
    logic         tx_enable;
    logic [63:0]  tx_state;

    int           compared   = 0;
    int           mismatched = 0;
    int           cyc        = 0;
    exp_t         sb[$];
    exp_t         mon_e;
    logic [63:0]  err_words [0:2*N-1];
    logic [127:0] key_a;

    leak_recover #(.NUM_FRAMES(N), .LFSR_SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Capacitance (Capacitance),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .busy        (busy),
        .disagree    (disagree)
    );

    lfsr64 u_tx (
        .clk    (clk),
        .rst    (rst),
        .load   (tx_load),
        .enable (tx_enable),
        .seed   (SEED),
        .state  (tx_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_step(input logic [63:0] s);
        logic fb;
        fb = s[63] ^ s[62] ^ s[60] ^ s[59];
        return {s[62:0], fb};
    endfunction

    // Per-bit vote over the frames as the receiver should decode them
    function automatic exp_t model_vote(input logic [127:0] key, input int start_cyc);
        exp_t e;
        int   cnt;
        int   j;
        e.key = '0;
        e.dis = 1'b0;
        e.at  = start_cyc + 2 * N + 1;
        for (int i = 0; i < 128; i++) begin
            cnt = 0;
            for (int f = 0; f < N; f++) begin
                j = 2 * f + ((i >= 64) ? 1 : 0);
                cnt += int'(key[i] ^ err_words[j][i % 64]);
            end
            e.key[i] = (2 * cnt > N);
            if (cnt != 0 && cnt != N) e.dis = 1'b1;
        end
        return e;
    endfunction

    task automatic clearErrors();
        for (int j = 0; j < 2 * N; j++) err_words[j] = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
    endtask

    // Pulses start, then drives n_busy whitened words; returns inside the last one
    task automatic applyStimulus(input logic [127:0] key, input int n_busy, input bit expect_key);
        logic [63:0] lf;
        logic [63:0] word;
        @(posedge clk); #1;
        start       = 1'b1;
        tx_load     = 1'b1;
        tx_enable   = 1'b0;
        Capacitance = {$urandom, $urandom};
        if (expect_key) sb.push_back(model_vote(key, cyc));
        lf = SEED;
        for (int j = 0; j < n_busy; j++) begin
            @(posedge clk); #1;
            start       = 1'b0;
            tx_load     = 1'b0;
            tx_enable   = 1'b1;
            word        = (j % 2 == 0) ? key[63:0] : key[127:64];
            Capacitance = word ^ lf ^ err_words[j];
            checkOutput("busy_capture", 128'(busy), 128'(1));
            checkOutput("tx_lfsr", 128'(tx_state), 128'(lf));
            lf = model_step(lf);
        end
        tx_enable = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_key_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("key_out", key_out, mon_e.key);
                    checkOutput("disagree", 128'(disagree), 128'(mon_e.dis));
                    checkOutput("latency", 128'(cyc), 128'(mon_e.at));
                    checkOutput("busy_vote", 128'(busy), 128'(0));
                end
            end else begin
                checkOutput("disagree_idle", 128'(disagree), 128'(0));
            end
        end
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        Capacitance = '0;
        tx_load     = 1'b0;
        tx_enable   = 1'b0;
        clearErrors();
        key_a = 128'h000102030405060708090A0B0C0D0E0F;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_key_out", key_out, 128'(0));
        checkOutput("reset_key_valid", 128'(key_valid), 128'(0));
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_disagree", 128'(disagree), 128'(0));
        rst = 1'b0;
        idle(2);

        applyStimulus(128'(0), 2 * N, 1'b1);
        idle(2);
        applyStimulus(key_a, 2 * N, 1'b1);
        idle(2);

        err_words[2] = 64'h20;
        applyStimulus(key_a, 2 * N, 1'b1);
        clearErrors();
        idle(2);

        // Restart in the middle of a capture
        applyStimulus(key_a, 3, 1'b0);
        applyStimulus({128{1'b1}}, 2 * N, 1'b1);
        idle(2);

        // Reset mid-capture abandons it
        applyStimulus(key_a ^ 128'h55, 4, 1'b0);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_key_out", key_out, 128'(0));
        rst = 1'b0;
        idle(2);

        // Back-to-back: second start lands in the VOTE cycle
        applyStimulus(key_a, 2 * N, 1'b1);
        applyStimulus(~key_a, 2 * N, 1'b1);
        idle(2);

        for (int t = 0; t < 12; t++) begin
            for (int j = 0; j < 2 * N; j++) begin
                err_words[j] = ($urandom_range(0, 2) == 0) ?
                    ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}) : 64'h0;
            end
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 2 * N, 1'b1);
            clearErrors();
            idle($urandom_range(0, 2));
        end
        idle(1);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("scoreboard_drained", 128'(sb.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
